// File: rtl/z16_pkg.sv
// Shared opcode map, ALU control codes and instruction field positions
// for the Z16 16-bit instruction format.
package z16_pkg;

  typedef enum logic [3:0] {
    OP_R_FIRST = 4'h0,
    OP_R_LAST  = 4'h8,
    OP_ADDI    = 4'h9,
    OP_LOAD    = 4'hA,
    OP_STORE   = 4'hB,
    OP_JAL     = 4'hC,
    OP_JRL     = 4'hD,
    OP_BRANCH  = 4'hE,
    OP_ILLEGAL = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_CMP = 4'h4
  } alu_ctrl_e;

  localparam int OPC_W    = 4;
  localparam int ALU_W    = 4;
  localparam int OPC_LSB  = 0;
  localparam int RD_LSB   = 4;
  localparam int RS1_LSB  = 8;
  localparam int RS2_LSB  = 12;
  localparam int IMM8_LSB = 8;
  localparam int IMM8_W   = 8;
  localparam int IMM4_LSB = 12;
  localparam int IMM4_W   = 4;

endpackage

// File: rtl/z16_decode_comb.sv
// Purely combinational field extraction and control decode of one Z16 instruction.
module z16_decode_comb
  import z16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic                     instr_in,
  input  logic [DATA_W-1:0]        instr,
  output logic [OPC_W-1:0]         opecode,
  output logic [REG_AW-1:0]        rd_addr,
  output logic [REG_AW-1:0]        rs1_addr,
  output logic [REG_AW-1:0]        rs2_addr,
  output logic signed [DATA_W-1:0] imm,
  output logic                     rd_wen,
  output logic                     mem_wen,
  output logic                     mem_ren,
  output logic                     jump,
  output logic                     branch,
  output logic                     illegal,
  output logic [ALU_W-1:0]         alu_ctrl
);

  function automatic logic signed [DATA_W-1:0] sext8(input logic signed [IMM8_W-1:0] f);
    return {{(DATA_W-IMM8_W){f[IMM8_W-1]}}, f};
  endfunction

  function automatic logic signed [DATA_W-1:0] sext4(input logic signed [IMM4_W-1:0] f);
    return {{(DATA_W-IMM4_W){f[IMM4_W-1]}}, f};
  endfunction

  always_comb begin
    opecode  = instr[OPC_LSB +: OPC_W];
    rd_addr  = instr[RD_LSB  +: REG_AW];
    rs1_addr = instr[RS1_LSB +: REG_AW];
    rs2_addr = instr[RS2_LSB +: REG_AW];
    imm      = '0;
    rd_wen   = 1'b0;
    mem_wen  = 1'b0;
    mem_ren  = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    alu_ctrl = ALU_ADD;
    case (opecode)
      OP_ADDI: begin
        // ADDI is two-operand: the destination is also the source
        rd_wen   = 1'b1;
        rs1_addr = instr[RD_LSB +: REG_AW];
        imm      = sext8(instr[IMM8_LSB +: IMM8_W]);
      end
      OP_LOAD: begin
        rd_wen  = 1'b1;
        mem_ren = 1'b1;
        imm     = sext4(instr[IMM4_LSB +: IMM4_W]);
      end
      OP_STORE: begin
        mem_wen = 1'b1;
        imm     = sext4(instr[IMM4_LSB +: IMM4_W]);
      end
      OP_JAL: begin
        jump   = 1'b1;
        rd_wen = 1'b1;
        imm    = sext8(instr[IMM8_LSB +: IMM8_W]);
      end
      OP_JRL: begin
        jump   = 1'b1;
        rd_wen = 1'b1;
      end
      OP_BRANCH: begin
        branch   = 1'b1;
        alu_ctrl = ALU_CMP;
        imm      = sext4(instr[IMM4_LSB +: IMM4_W]);
      end
      OP_ILLEGAL: illegal = 1'b1;
      default: begin
        rd_wen   = 1'b1;
        alu_ctrl = opecode;
      end
    endcase
  end

endmodule

// File: rtl/z16_pipe_decoder.sv
// Registered Z16 decoder stage with valid/ready handshakes, a 1-entry skid
// buffer so o_ready never depends on i_ready, flush, and an illegal counter.
module z16_pipe_decoder
  import z16_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 4,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [DATA_W-1:0]    i_instr,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OPC_W-1:0]     o_opecode,
  output logic [REG_AW-1:0]    o_rd_addr,
  output logic [REG_AW-1:0]    o_rs1_addr,
  output logic [REG_AW-1:0]    o_rs2_addr,
  output logic [DATA_W-1:0]    o_imm,
  output logic                 o_rd_wen,
  output logic                 o_mem_wen,
  output logic                 o_mem_ren,
  output logic                 o_jump,
  output logic                 o_branch,
  output logic                 o_illegal,
  output logic [ALU_W-1:0]     o_alu_ctrl,
  output logic [ILL_CNT_W-1:0] o_ill_cnt
);

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [DATA_W-1:0]        skid_instr_p0, dec_instr_p0;
  logic                     skid_full_p0, ready_p0;
  logic                     in_fire, out_fire, load_out;
  logic [OPC_W-1:0]         d_opecode;
  logic [REG_AW-1:0]        d_rd, d_rs1, d_rs2;
  logic signed [DATA_W-1:0] d_imm;
  logic                     d_rd_wen, d_mem_wen, d_mem_ren, d_jump, d_branch, d_illegal;
  logic [ALU_W-1:0]         d_alu_ctrl;

  logic                     vld_p1;
  logic [OPC_W-1:0]         opecode_p1;
  logic [REG_AW-1:0]        rd_p1, rs1_p1, rs2_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic                     rd_wen_p1, mem_wen_p1, mem_ren_p1, jump_p1, branch_p1, illegal_p1;
  logic [ALU_W-1:0]         alu_ctrl_p1;
  logic [ILL_CNT_W-1:0]     ill_cnt_p1;

  assign in_fire  = i_valid && ready_p0;
  assign out_fire = vld_p1 && i_ready;
  assign load_out = !vld_p1 || i_ready;

  // Stage p0: the skid entry is older than the input, so it is decoded first
  assign dec_instr_p0 = skid_full_p0 ? skid_instr_p0 : i_instr;

  z16_decode_comb #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
    .instr_in (1'b0),
    .instr    (dec_instr_p0),
    .opecode  (d_opecode),
    .rd_addr  (d_rd),
    .rs1_addr (d_rs1),
    .rs2_addr (d_rs2),
    .imm      (d_imm),
    .rd_wen   (d_rd_wen),
    .mem_wen  (d_mem_wen),
    .mem_ren  (d_mem_ren),
    .jump     (d_jump),
    .branch   (d_branch),
    .illegal  (d_illegal),
    .alu_ctrl (d_alu_ctrl)
  );

  // Stage p1: output register, skid buffer and illegal counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_p0      <= 1'b0;
      skid_full_p0  <= 1'b0;
      skid_instr_p0 <= '0;
      vld_p1        <= 1'b0;
      opecode_p1    <= '0;
      rd_p1         <= '0;
      rs1_p1        <= '0;
      rs2_p1        <= '0;
      imm_p1        <= '0;
      rd_wen_p1     <= 1'b0;
      mem_wen_p1    <= 1'b0;
      mem_ren_p1    <= 1'b0;
      jump_p1       <= 1'b0;
      branch_p1     <= 1'b0;
      illegal_p1    <= 1'b0;
      alu_ctrl_p1   <= '0;
      ill_cnt_p1    <= '0;
    end else begin
      if (out_fire && illegal_p1) ill_cnt_p1 <= sat_inc(ill_cnt_p1);
      if (i_flush) begin
        vld_p1       <= 1'b0;
        skid_full_p0 <= 1'b0;
        ready_p0     <= 1'b1;
      end else if (load_out) begin
        vld_p1       <= skid_full_p0 || in_fire;
        skid_full_p0 <= 1'b0;
        ready_p0     <= 1'b1;
        if (skid_full_p0 || in_fire) begin
          opecode_p1  <= d_opecode;
          rd_p1       <= d_rd;
          rs1_p1      <= d_rs1;
          rs2_p1      <= d_rs2;
          imm_p1      <= d_imm;
          rd_wen_p1   <= d_rd_wen;
          mem_wen_p1  <= d_mem_wen;
          mem_ren_p1  <= d_mem_ren;
          jump_p1     <= d_jump;
          branch_p1   <= d_branch;
          illegal_p1  <= d_illegal;
          alu_ctrl_p1 <= d_alu_ctrl;
        end
      end else if (in_fire) begin
        skid_instr_p0 <= i_instr;
        skid_full_p0  <= 1'b1;
        ready_p0      <= 1'b0;
      end
    end
  end

  assign o_ready    = ready_p0;
  assign o_valid    = vld_p1;
  assign o_opecode  = opecode_p1;
  assign o_rd_addr  = rd_p1;
  assign o_rs1_addr = rs1_p1;
  assign o_rs2_addr = rs2_p1;
  assign o_imm      = imm_p1;
  assign o_rd_wen   = rd_wen_p1;
  assign o_mem_wen  = mem_wen_p1;
  assign o_mem_ren  = mem_ren_p1;
  assign o_jump     = jump_p1;
  assign o_branch   = branch_p1;
  assign o_illegal  = illegal_p1;
  assign o_alu_ctrl = alu_ctrl_p1;
  assign o_ill_cnt  = ill_cnt_p1;

endmodule

// File: tb/tb_z16_pipe_decoder.sv
// Table- and scoreboard-driven bench for z16_pipe_decoder: decode table,
// random backpressure stream, skid, flush, illegal saturation and async reset.
module tb_z16_pipe_decoder;

  typedef struct packed {
    logic [3:0]  opc;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        rd_wen;
    logic        mem_wen;
    logic        mem_ren;
    logic        jump;
    logic        branch;
    logic        illegal;
    logic [3:0]  alu;
  } dec_t;

  typedef struct {
    logic [15:0] instr;
    dec_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_instr = '0;
  logic        o_ready, o_valid;
  logic        i_ready = 1'b1;
  logic [3:0]  o_opecode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl;
  logic [15:0] o_imm;
  logic        o_rd_wen, o_mem_wen, o_mem_ren, o_jump, o_branch, o_illegal;
  logic [7:0]  o_ill_cnt;

  int   n_vec = 0;
  int   n_bad = 0;
  int   ill_exp = 0;
  bit   rand_rdy = 1'b0;
  dec_t q[$];
  dec_t mon_e;
  vec_t tbl[12];

  z16_pipe_decoder #(.DATA_W(16), .REG_AW(4), .ILL_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(i_flush),
    .i_valid(i_valid), .i_instr(i_instr), .o_ready(o_ready),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_opecode(o_opecode), .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr),
    .o_rs2_addr(o_rs2_addr), .o_imm(o_imm), .o_rd_wen(o_rd_wen),
    .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .o_jump(o_jump),
    .o_branch(o_branch), .o_illegal(o_illegal), .o_alu_ctrl(o_alu_ctrl),
    .o_ill_cnt(o_ill_cnt)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic dec_t act_dec();
    return '{o_opecode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm, o_rd_wen, o_mem_wen,
             o_mem_ren, o_jump, o_branch, o_illegal, o_alu_ctrl};
  endfunction

  // Reference decode written straight from the instruction-set table
  function automatic dec_t model(input logic [15:0] w);
    dec_t e;
    e = '0;
    e.opc = w[3:0];
    e.rd  = w[7:4];
    e.rs1 = w[11:8];
    e.rs2 = w[15:12];
    if (w[3:0] <= 4'h8) begin
      e.rd_wen = 1'b1; e.alu = w[3:0];
    end else if (w[3:0] == 4'h9) begin
      e.rd_wen = 1'b1; e.rs1 = w[7:4]; e.imm = 16'($signed(w[15:8]));
    end else if (w[3:0] == 4'hA) begin
      e.rd_wen = 1'b1; e.mem_ren = 1'b1; e.imm = 16'($signed(w[15:12]));
    end else if (w[3:0] == 4'hB) begin
      e.mem_wen = 1'b1; e.imm = 16'($signed(w[15:12]));
    end else if (w[3:0] == 4'hC) begin
      e.jump = 1'b1; e.rd_wen = 1'b1; e.imm = 16'($signed(w[15:8]));
    end else if (w[3:0] == 4'hD) begin
      e.jump = 1'b1; e.rd_wen = 1'b1;
    end else if (w[3:0] == 4'hE) begin
      e.branch = 1'b1; e.alu = 4'h4; e.imm = 16'($signed(w[15:12]));
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: pop on every downstream transfer
  always @(negedge clk) begin
    if (rst) begin
    end else if (i_flush) begin
      q.delete();
    end else if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_xfer", 64'(act_dec()), 64'hDEAD_0000_0000);
      end else begin
        mon_e = q.pop_front();
        chk("xfer", 64'(act_dec()), 64'(mon_e));
        chk("ill_cnt", 64'(o_ill_cnt), 64'(ill_exp));
        if (mon_e.illegal && ill_exp != 255) ill_exp++;
      end
    end
  end

  task automatic send(input logic [15:0] ins, input dec_t e);
    bit acc;
    bit done;
    done = 1'b0;
    i_valid = 1'b1;
    i_instr = ins;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      acc = o_ready && !i_flush;
      @(posedge clk);
      #1;
      if (acc) begin
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 64'(o_ready), 64'd1);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    rand_rdy = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_idle", 64'(o_valid), 64'd0);
  endtask

  initial begin
    int          nacc;
    bit          acc;
    logic [15:0] seq [3];
    logic [15:0] w;

    tbl[0]  = '{16'hF09A, '{4'hA, 4'h9, 4'h0, 4'hF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0}};
    tbl[1]  = '{16'h8039, '{4'h9, 4'h3, 4'h3, 4'h8, 16'hFF80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}};
    tbl[2]  = '{16'h1234, '{4'h4, 4'h3, 4'h2, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4}};
    tbl[3]  = '{16'h7650, '{4'h0, 4'h5, 4'h6, 4'h7, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}};
    tbl[4]  = '{16'h4578, '{4'h8, 4'h7, 4'h5, 4'h4, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8}};
    tbl[5]  = '{16'h312B, '{4'hB, 4'h2, 4'h1, 4'h3, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}};
    tbl[6]  = '{16'h7F5C, '{4'hC, 4'h5, 4'hF, 4'h7, 16'h007F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0}};
    tbl[7]  = '{16'h80AC, '{4'hC, 4'hA, 4'h0, 4'h8, 16'hFF80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0}};
    tbl[8]  = '{16'hABCD, '{4'hD, 4'hC, 4'hB, 4'hA, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0}};
    tbl[9]  = '{16'h9A1E, '{4'hE, 4'h1, 4'hA, 4'h9, 16'hFFF9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4}};
    tbl[10] = '{16'h543F, '{4'hF, 4'h3, 4'h4, 4'h5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0}};
    tbl[11] = '{16'h7069, '{4'h9, 4'h6, 4'h6, 4'h7, 16'h0070, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0}};
    seq[0] = 16'h1231;
    seq[1] = 16'h4562;
    seq[2] = 16'h7893;

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_outs", 64'(act_dec()), 64'd0);
    chk("rst_cnt", 64'(o_ill_cnt), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(o_ready), 64'd1);

    // Decode table, first entry also checks one-cycle latency
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].instr, tbl[i].exp);
      if (i == 0) chk("latency_valid", 64'(o_valid), 64'd1);
    end
    drain();

    // Random stream under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      w = 16'($urandom);
      send(w, model(w));
      if ($urandom_range(0, 4) == 0) begin
        i_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Stall for 3 cycles: exactly two accepted, first stays on the output
    i_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1;
      i_instr = seq[nacc];
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        q.push_back(model(seq[nacc]));
        nacc++;
      end
    end
    chk("stall_accepts", 64'(nacc), 64'd2);
    chk("stall_ready", 64'(o_ready), 64'd0);
    chk("stall_hold", 64'(act_dec()), 64'(model(seq[0])));
    drain();

    // Flush with the skid full; flushed items must never surface
    i_ready = 1'b0;
    send(16'h2221, model(16'h2221));
    send(16'h3332, model(16'h3332));
    chk("skid_full_ready", 64'(o_ready), 64'd0);
    i_valid = 1'b1;
    i_instr = 16'h4443;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    send(tbl[5].instr, tbl[5].exp);
    drain();

    // 300 illegal transfers, counter must stick at 255
    for (int i = 0; i < 300; i++) begin
      w = {12'($urandom), 4'hF};
      send(w, model(w));
    end
    drain();
    chk("ill_saturated", 64'(o_ill_cnt), 64'd255);

    // Asynchronous reset in the middle of a stalled stream
    i_ready = 1'b0;
    send(tbl[1].instr, tbl[1].exp);
    send(tbl[6].instr, tbl[6].exp);
    #3 rst = 1'b1;
    #1;
    i_valid = 1'b0;
    q.delete();
    ill_exp = 0;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd0);
    chk("midrst_outs", 64'(act_dec()), 64'd0);
    chk("midrst_cnt", 64'(o_ill_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_ready_low", 64'(o_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("release_ready", 64'(o_ready), 64'd1);
    chk("release_valid", 64'(o_valid), 64'd0);
    i_ready = 1'b1;
    send(tbl[10].instr, tbl[10].exp);
    drain();
    chk("post_rst_cnt", 64'(o_ill_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/z16_pipe_decoder.md
Z16_PIPE_DECODER -- requirements
Module: z16_pipe_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction and immediate width (min 16).
REQ-002 SHALL have parameter REG_AW, default 4, meaning register address width.
REQ-003 SHALL have parameter ILL_CNT_W, default 8, meaning illegal-instruction counter width.
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port i_flush, input, 1, a synchronous pipeline flush.
REQ-007 SHALL have ports i_valid (input, 1), i_instr (input, DATA_W) and o_ready (output, 1), forming the upstream handshake.
REQ-008 SHALL have ports o_valid (output, 1) and i_ready (input, 1), forming the downstream handshake.
REQ-009 SHALL have outputs o_opecode 4, o_rd_addr REG_AW, o_rs1_addr REG_AW, o_rs2_addr REG_AW and o_imm DATA_W.
REQ-010 SHALL have 1-bit outputs o_rd_wen, o_mem_wen, o_mem_ren, o_jump, o_branch and o_illegal, plus o_alu_ctrl 4.
REQ-011 SHALL have output o_ill_cnt, ILL_CNT_W wide.

Function
REQ-012 SHALL extract fields as: opecode=instr[3:0], rd=instr[7:4], rs1=instr[11:8], rs2=instr[15:12].
REQ-013 SHALL decode 0x0-0x8 (R-type) as: rd_wen=1, alu_ctrl=opecode, imm=0.
REQ-014 SHALL decode 0x9 (ADDI) as: rd_wen=1, alu_ctrl=0, imm=sext(instr[15:8]), rs1=rd field.
REQ-015 SHALL decode 0xA (LOAD) as: rd_wen=1, mem_ren=1, alu_ctrl=0, imm=sext(instr[15:12]).
REQ-016 SHALL decode 0xB (STORE) as: mem_wen=1, rd_wen=0, alu_ctrl=0, imm=sext(instr[15:12]).
REQ-017 SHALL decode 0xC (JAL) as: jump=1, rd_wen=1, imm=sext(instr[15:8]); and 0xD (JRL) as: jump=1, rd_wen=1, imm=0.
REQ-018 SHALL decode 0xE (BRANCH) as: branch=1, rd_wen=0, alu_ctrl=4 (compare), imm=sext(instr[15:12]).
REQ-019 SHALL decode 0xF as: illegal=1 with all enables 0, and still present the instruction downstream.
REQ-020 SHALL perform every sign extension by replicating the field MSB up to DATA_W.
REQ-021 SHALL register all decoded outputs: an instruction accepted in cycle N appears with o_valid=1 in cycle N+1.
REQ-022 SHALL accept on i_valid&&o_ready and transfer out on o_valid&&i_ready.
REQ-023 SHALL drive o_ready from a register as !skid_full, never combinationally from i_ready.
REQ-024 SHALL capture an accepted instruction in a 1-entry skid buffer when the output is held (o_valid&&!i_ready).
REQ-025 SHALL keep outputs stable while o_valid&&!i_ready.
REQ-026 SHALL, when the output drains, load it from the skid buffer before new input, preserving order.
REQ-027 SHALL allow simultaneous accept and drain with an empty skid, with output reloading directly at 100% throughput.
REQ-028 SHALL, on i_flush, clear o_valid and the skid in the next cycle and discard any same-cycle accept; flush has priority over all.
REQ-029 SHALL increment o_ill_cnt once per illegal instruction transferred downstream, saturating at all-ones; flushed illegals are not counted.

Reset
REQ-030 SHALL, on i_rst asserted, asynchronously clear o_valid, the skid buffer, all decoded outputs and o_ill_cnt to 0, and drive o_ready 0.
REQ-031 SHALL drive o_ready 1 on the first clock after i_rst deasserts.
REQ-032 SHALL lose any in-flight instruction on reset mid-operation, with no partial output.

Structure
REQ-033 SHALL take opcode constants, ALU control codes and field bit positions from shared package z16_pkg.
REQ-034 SHALL place the pure field and control decode in sub-module z16_decode_comb, instantiated once before the pipeline register.

Verification
REQ-035 SHALL verify: i_instr=16'hF09A, i_ready=1 -> next cycle o_rd_addr=9, o_rs1_addr=0, o_imm=16'hFFFF, o_rd_wen=1, o_mem_ren=1.
REQ-036 SHALL verify: i_instr=16'h8039 -> o_opecode=9, o_rd_addr=3, o_imm=16'hFF80, o_alu_ctrl=0.
REQ-037 SHALL verify: continuous valid input with i_ready=0 for 3 cycles -> exactly 2 accepted, o_ready=0 thereafter, in-order delivery with no loss or duplication after i_ready=1.
REQ-038 SHALL verify: i_flush with skid full -> next cycle o_valid=0 and o_ready=1, and the flushed instructions never appear.
REQ-039 SHALL verify: 300 transferred instructions with opcode 0xF -> o_illegal=1 each, and o_ill_cnt saturates at 255.
REQ-040 SHALL verify: i_rst asserted mid-stream between clock edges -> outputs 0 immediately, and o_ready=1 one cycle after release.
